// File: rtl/uart_rx_hello_detect_if.sv
// Serial receive bus for uart_rx_hello_detect: rx line in,
// received byte, strobes and match counter out.
interface uart_rx_hello_detect_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       match;
    logic [7:0] match_count;

    modport master (
        output rx,
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  match,
        input  match_count
    );

    modport slave (
        input  rx,
        output rx_data,
        output rx_valid,
        output frame_err,
        output match,
        output match_count
    );
endinterface

// File: rtl/uart_rx_hello_detect.sv
// 8N1 UART receiver with a "HELLO\r\n" sequence matcher
// and wrapping match counter.
module uart_rx_hello_detect #(
    parameter int CLK_FREQ  = 27000000,
    parameter int BAUD_RATE = 115200,
    parameter int MSG_LEN   = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_rx_hello_detect_if.slave  bus
);
    localparam int CPB  = CLK_FREQ / BAUD_RATE;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB + 1);

    localparam logic [CW-1:0] HALF_END = CW'(HALF - 1);
    localparam logic [CW-1:0] CPB_END  = CW'(CPB - 1);
    localparam logic [2:0]    IDX_LAST = 3'(MSG_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAITHI
    } state_t;

    function automatic logic [7:0] rom(input logic [2:0] i);
        logic [7:0] b;
        b = 8'h00;
        case (i)
            3'd0:    b = 8'h48;
            3'd1:    b = 8'h45;
            3'd2:    b = 8'h4C;
            3'd3:    b = 8'h4C;
            3'd4:    b = 8'h4F;
            3'd5:    b = 8'h0D;
            3'd6:    b = 8'h0A;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    logic          r_sync1;
    logic          r_rxs;
    state_t        r_state;
    state_t        w_state;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt;
    logic [2:0]    r_bit;
    logic [2:0]    w_bit;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift;
    logic [7:0]    r_data;
    logic [7:0]    w_data;
    logic          r_valid;
    logic          w_valid;
    logic          r_ferr;
    logic          w_ferr;
    logic [2:0]    r_idx;
    logic          r_match;
    logic [7:0]    r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_sync1 <= bus.rx;
            r_rxs   <= r_sync1;
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_bit   <= w_bit;
            r_shift <= w_shift;
            r_data  <= w_data;
            r_valid <= w_valid;
            r_ferr  <= w_ferr;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt + 1'b1;
        w_bit   = r_bit;
        w_shift = r_shift;
        w_data  = r_data;
        w_valid = 1'b0;
        w_ferr  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_cnt = '0;
                if (!r_rxs) w_state = START;
            end
            START: begin
                // Mid-start-bit check rejects short glitches
                if (r_cnt == HALF_END) begin
                    w_cnt   = '0;
                    w_bit   = '0;
                    w_state = r_rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_cnt == CPB_END) begin
                    w_cnt          = '0;
                    w_shift[r_bit] = r_rxs;
                    w_bit          = r_bit + 3'd1;
                    if (r_bit == 3'd7) w_state = STOP;
                end
            end
            STOP: begin
                if (r_cnt == CPB_END) begin
                    w_cnt = '0;
                    if (r_rxs) begin
                        w_data  = r_shift;
                        w_valid = 1'b1;
                        w_state = IDLE;
                    end else begin
                        w_ferr  = 1'b1;
                        w_state = WAITHI;
                    end
                end
            end
            WAITHI: begin
                w_cnt = '0;
                if (r_rxs) w_state = IDLE;
            end
            default: begin
                w_cnt   = '0;
                w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_match <= 1'b0;
            r_count <= '0;
        end else begin
            r_match <= 1'b0;
            if (r_ferr) begin
                r_idx <= '0;
            end else if (r_valid) begin
                if (r_data == rom(r_idx)) begin
                    if (r_idx == IDX_LAST) begin
                        r_idx   <= '0;
                        r_match <= 1'b1;
                        r_count <= r_count + 8'd1;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end else begin
                    // A stray 'H' may itself begin a new sequence
                    r_idx <= (r_data == 8'h48) ? 3'd1 : 3'd0;
                end
            end
        end
    end

    assign bus.rx_data     = r_data;
    assign bus.rx_valid    = r_valid;
    assign bus.frame_err   = r_ferr;
    assign bus.match       = r_match;
    assign bus.match_count = r_count;
endmodule

// File: tb/tb_uart_rx_hello_detect.sv
// Directed testbench for uart_rx_hello_detect at default
// 27 MHz / 115200 baud.
module tb_uart_rx_hello_detect;
    localparam int CPB = 234;
    localparam int LAT = 2226;

    logic clk = 1'b0;
    logic rst;
    uart_rx_hello_detect_if bus ();

    uart_rx_hello_detect dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int n_valid = 0;
    int n_ferr = 0;
    int n_match = 0;
    int n_both = 0;
    int last_valid_cyc = 0;
    int last_lf_cyc = 0;
    int last_match_cyc = 0;
    logic [7:0] last_byte = 8'h00;

    logic [7:0] hello [7] = '{8'h48, 8'h45, 8'h4C, 8'h4C,
                              8'h4F, 8'h0D, 8'h0A};
    logic [7:0] help [6] = '{8'h48, 8'h45, 8'h4C, 8'h50,
                             8'h0D, 8'h0A};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rx_valid) begin
            n_valid        <= n_valid + 1;
            last_valid_cyc <= cyc;
            last_byte      <= bus.rx_data;
            if (bus.rx_data == 8'h0A) last_lf_cyc <= cyc;
        end
        if (bus.frame_err) n_ferr <= n_ferr + 1;
        if (bus.match) begin
            n_match        <= n_match + 1;
            last_match_cyc <= cyc;
        end
        if (bus.rx_valid && bus.frame_err) n_both <= n_both + 1;
    end

    task automatic send_bit(input logic b);
        bus.rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b,
                             input logic stop);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_hello;
        for (int i = 0; i < 7; i++) send_byte(hello[i], 1'b1);
        idle(5);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.rx_data !== 8'h00 || bus.rx_valid !== 1'b0 ||
            bus.frame_err !== 1'b0 || bus.match !== 1'b0 ||
            bus.match_count !== 8'h00) begin
            bad++;
            $display("FAIL reset_outputs got %h %b %b %b %h want 00 0 0 0 00",
                     bus.rx_data, bus.rx_valid, bus.frame_err,
                     bus.match, bus.match_count);
        end
        rst = 1'b0;
        idle(20);
        total++;
        if (n_valid !== 0 || n_ferr !== 0) begin
            bad++;
            $display("FAIL reset_idle_quiet got valid=%0d ferr=%0d want 0 0",
                     n_valid, n_ferr);
        end
    endtask

    task automatic test_single_byte;
        int v0, f0, lat;
        v0 = n_valid;
        f0 = n_ferr;
        send_byte(8'h48, 1'b1);
        idle(20);
        lat = last_valid_cyc - start_cyc;
        total++;
        if (n_valid - v0 !== 1) begin
            bad++;
            $display("FAIL single_count got %0d want 1", n_valid - v0);
        end
        total++;
        if (last_byte !== 8'h48) begin
            bad++;
            $display("FAIL single_data got %h want 48", last_byte);
        end
        total++;
        if (lat < LAT - 1 || lat > LAT + 1) begin
            bad++;
            $display("FAIL single_latency got %0d want %0d", lat, LAT);
        end
        total++;
        if (n_ferr !== f0) begin
            bad++;
            $display("FAIL single_ferr got %0d want %0d", n_ferr, f0);
        end
    endtask

    task automatic test_hello_repeat;
        int v0, m0;
        v0 = n_valid;
        m0 = n_match;
        send_hello();
        total++;
        if (n_valid - v0 !== 7) begin
            bad++;
            $display("FAIL hello_valids got %0d want 7", n_valid - v0);
        end
        total++;
        if (n_match - m0 !== 1) begin
            bad++;
            $display("FAIL hello_match got %0d want 1", n_match - m0);
        end
        total++;
        if (last_match_cyc !== last_lf_cyc + 1) begin
            bad++;
            $display("FAIL hello_match_timing got %0d want %0d",
                     last_match_cyc, last_lf_cyc + 1);
        end
        total++;
        if (bus.match_count !== 8'd1) begin
            bad++;
            $display("FAIL hello_count1 got %0d want 1", bus.match_count);
        end
        send_hello();
        send_hello();
        total++;
        if (bus.match_count !== 8'd3) begin
            bad++;
            $display("FAIL hello_count3 got %0d want 3", bus.match_count);
        end
    endtask

    task automatic test_restart;
        int m0;
        m0 = n_match;
        for (int i = 0; i < 6; i++) send_byte(help[i], 1'b1);
        idle(5);
        total++;
        if (n_match !== m0) begin
            bad++;
            $display("FAIL help_nomatch got %0d want %0d", n_match, m0);
        end
        send_byte(8'h48, 1'b1);
        send_hello();
        total++;
        if (n_match - m0 !== 1) begin
            bad++;
            $display("FAIL hhello_match got %0d want 1", n_match - m0);
        end
        total++;
        if (bus.match_count !== 8'd4) begin
            bad++;
            $display("FAIL hhello_count got %0d want 4", bus.match_count);
        end
    endtask

    task automatic test_frame_err;
        int v0, f0, m0;
        v0 = n_valid;
        f0 = n_ferr;
        send_byte(8'h41, 1'b0);
        bus.rx = 1'b0;
        repeat (5000) @(posedge clk);
        #1;
        idle(300);
        total++;
        if (n_ferr - f0 !== 1) begin
            bad++;
            $display("FAIL ferr_count got %0d want 1", n_ferr - f0);
        end
        total++;
        if (n_valid !== v0) begin
            bad++;
            $display("FAIL ferr_novalid got %0d want %0d", n_valid, v0);
        end
        total++;
        if (bus.rx_data !== 8'h0A) begin
            bad++;
            $display("FAIL ferr_data_held got %h want 0a", bus.rx_data);
        end
        m0 = n_match;
        send_hello();
        total++;
        if (n_match - m0 !== 1 || bus.match_count !== 8'd5) begin
            bad++;
            $display("FAIL ferr_then_hello got %0d/%0d want 1/5",
                     n_match - m0, bus.match_count);
        end
    endtask

    task automatic test_glitch;
        int v0, f0, lat;
        v0 = n_valid;
        f0 = n_ferr;
        bus.rx = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        idle(300);
        total++;
        if (n_valid !== v0 || n_ferr !== f0) begin
            bad++;
            $display("FAIL glitch_quiet got %0d/%0d want %0d/%0d",
                     n_valid, n_ferr, v0, f0);
        end
        send_byte(8'hC3, 1'b1);
        idle(10);
        lat = last_valid_cyc - start_cyc;
        total++;
        if (last_byte !== 8'hC3 || lat < LAT - 1 || lat > LAT + 1) begin
            bad++;
            $display("FAIL glitch_recover got %h lat=%0d want c3 lat=%0d",
                     last_byte, lat, LAT);
        end
    endtask

    task automatic test_mid_reset;
        int v0, f0;
        logic [7:0] b;
        b = 8'h55;
        v0 = n_valid;
        f0 = n_ferr;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        bus.rx = b[4];
        repeat (100) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++;
        if (bus.rx_data !== 8'h00 || bus.rx_valid !== 1'b0 ||
            bus.frame_err !== 1'b0 || bus.match !== 1'b0 ||
            bus.match_count !== 8'h00) begin
            bad++;
            $display("FAIL midreset_outputs got %h %b %b %b %h want 00 0 0 0 00",
                     bus.rx_data, bus.rx_valid, bus.frame_err,
                     bus.match, bus.match_count);
        end
        idle(2000);
        total++;
        if (n_valid !== v0 || n_ferr !== f0) begin
            bad++;
            $display("FAIL midreset_nostrobe got %0d/%0d want %0d/%0d",
                     n_valid, n_ferr, v0, f0);
        end
        send_byte(8'h55, 1'b1);
        idle(10);
        total++;
        if (n_valid - v0 !== 1 || last_byte !== 8'h55) begin
            bad++;
            $display("FAIL midreset_next got %0d/%h want 1/55",
                     n_valid - v0, last_byte);
        end
        total++;
        if (bus.match_count !== 8'd0) begin
            bad++;
            $display("FAIL midreset_count got %0d want 0", bus.match_count);
        end
    endtask

    task automatic test_exclusive;
        total++;
        if (n_both !== 0) begin
            bad++;
            $display("FAIL valid_ferr_overlap got %0d want 0", n_both);
        end
    endtask

    initial begin
        bus.rx = 1'b1;
        rst = 1'b1;
        #1;
        test_reset();
        test_single_byte();
        test_hello_repeat();
        test_restart();
        test_frame_err();
        test_glitch();
        test_mid_reset();
        test_exclusive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
